// File: rtl/ser2para_rx_if.sv
// Bus bundle for ser2para_rx: the serial line in, the recovered 40-bit frame and status out.
// master = the side that drives ser_i, slave = the receiver.
interface ser2para_rx_if;
    logic        ser_i;
    logic [39:0] para_o;
    logic        para_vld;
    logic        locked;
    logic        frame_err;

    modport master (
        output ser_i,
        input  para_o,
        input  para_vld,
        input  locked,
        input  frame_err
    );

    modport slave (
        input  ser_i,
        output para_o,
        output para_vld,
        output locked,
        output frame_err
    );
endinterface

// File: rtl/ser2para_rx.sv
// Serial-to-parallel frame receiver: edge-tracked mid-bit sampling, header hunt/lock, 40-bit word out.
// Optional build macro SER2PARA_GLITCH_FILTER_EN inserts a 3-tap majority filter after the synchroniser.
module ser2para_rx #(
    parameter int unsigned             DIV      = 1000,
    parameter int unsigned             HDR_W    = 8,
    parameter logic [HDR_W-1:0]        HDR      = 8'hA5,
    parameter int unsigned             MISS_MAX = 3
) (
    input  logic           clk,
    input  logic           rst_n,
    ser2para_rx_if.slave   bus
);
    localparam int unsigned FRAME_W = 40;
    localparam int unsigned CNT_W   = 14;
    localparam int unsigned MISS_W  = $clog2(MISS_MAX) + 1;

    typedef enum logic {HUNT = 1'b0, LOCK = 1'b1} state_t;

    state_t               state_q, state_d;
    logic                 sync1_q, sync2_q, ser_d_q;
    logic                 ser_s;
    logic [CNT_W-1:0]     div_cnt_q, div_cnt_d;
    logic [FRAME_W-2:0]   sh_q, sh_d;
    logic [5:0]           fill_cnt_q, fill_cnt_d;
    logic [5:0]           bit_cnt_q, bit_cnt_d;
    logic [MISS_W-1:0]    miss_cnt_q, miss_cnt_d;
    logic [FRAME_W-1:0]   para_q, para_d;
    logic                 vld_q, vld_d;
    logic                 err_q, err_d;
    logic                 edge_w, strobe, hdr_ok, boundary;
    logic [FRAME_W-1:0]   word;

    function automatic logic [5:0] fill_inc(input logic [5:0] v);
        return (v == 6'd40) ? v : v + 6'd1;
    endfunction

    function automatic logic [MISS_W-1:0] miss_inc(input logic [MISS_W-1:0] v);
        return (&v) ? v : v + MISS_W'(1);
    endfunction

`ifdef SER2PARA_GLITCH_FILTER_EN
    logic hist1_q, hist2_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hist1_q <= 1'b0;
            hist2_q <= 1'b0;
        end else begin
            hist1_q <= sync2_q;
            hist2_q <= hist1_q;
        end
    end

    // A single-cycle pulse never wins the 2-of-3 vote.
    assign ser_s = (sync2_q & hist1_q) | (sync2_q & hist2_q) | (hist1_q & hist2_q);
`else
    assign ser_s = sync2_q;
`endif

    assign edge_w   = ser_s ^ ser_d_q;
    assign strobe   = (div_cnt_q == CNT_W'(DIV / 2 - 1)) && !edge_w;
    assign word     = {sh_q, ser_s};
    assign hdr_ok   = (word[FRAME_W-1 -: HDR_W] == HDR);
    assign boundary = (bit_cnt_q == 6'd39);

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= HUNT;
        else        state_q <= state_d;
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        if (strobe) begin
            case (state_q)
                HUNT: if (fill_cnt_q >= 6'd39 && hdr_ok) state_d = LOCK;
                LOCK: if (boundary && !hdr_ok && miss_cnt_q == MISS_W'(MISS_MAX - 1)) state_d = HUNT;
                default: state_d = HUNT;
            endcase
        end
    end

    // Datapath and counters
    always_comb begin
        div_cnt_d  = edge_w ? '0 : ((div_cnt_q == CNT_W'(DIV - 1)) ? '0 : div_cnt_q + CNT_W'(1));
        sh_d       = sh_q;
        fill_cnt_d = fill_cnt_q;
        bit_cnt_d  = bit_cnt_q;
        miss_cnt_d = miss_cnt_q;
        para_d     = para_q;
        vld_d      = 1'b0;
        err_d      = 1'b0;
        if (strobe) begin
            sh_d       = word[FRAME_W-2:0];
            fill_cnt_d = fill_inc(fill_cnt_q);
            if (state_q == HUNT) begin
                if (fill_cnt_q >= 6'd39 && hdr_ok) begin
                    para_d     = word;
                    vld_d      = 1'b1;
                    bit_cnt_d  = '0;
                    miss_cnt_d = '0;
                end
            end else if (!boundary) begin
                bit_cnt_d = bit_cnt_q + 6'd1;
            end else begin
                bit_cnt_d = '0;
                if (hdr_ok) begin
                    para_d     = word;
                    vld_d      = 1'b1;
                    miss_cnt_d = '0;
                end else begin
                    err_d      = 1'b1;
                    miss_cnt_d = (miss_cnt_q == MISS_W'(MISS_MAX - 1)) ? '0 : miss_inc(miss_cnt_q);
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q    <= 1'b0;
            sync2_q    <= 1'b0;
            ser_d_q    <= 1'b0;
            div_cnt_q  <= '0;
            sh_q       <= '0;
            fill_cnt_q <= '0;
            bit_cnt_q  <= '0;
            miss_cnt_q <= '0;
            para_q     <= '0;
            vld_q      <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            sync1_q    <= bus.ser_i;
            sync2_q    <= sync1_q;
            ser_d_q    <= ser_s;
            div_cnt_q  <= div_cnt_d;
            sh_q       <= sh_d;
            fill_cnt_q <= fill_cnt_d;
            bit_cnt_q  <= bit_cnt_d;
            miss_cnt_q <= miss_cnt_d;
            para_q     <= para_d;
            vld_q      <= vld_d;
            err_q      <= err_d;
        end
    end

    // Outputs
    always_comb begin
        bus.para_o    = para_q;
        bus.para_vld  = vld_q;
        bus.frame_err = err_q;
        bus.locked    = (state_q == LOCK);
    end
endmodule
